pixel_ingress: RTL and testbench
================================

# pixel_ingress

Parametrised successor to the frame input interface. Accepts a valid/ready pixel stream carrying NCH channels per beat and buffers it in an internal first-word-fall-through FIFO. Each beat is presented downstream on a valid/ready port, tagged with its column/row position and start/end-of-line/frame flags, and counted against a per-frame latched width/height. Sits between the external pixel source and the convolution line buffers.

## Interface
- XB, 10: column counter / cfg_width width
- YB, 10: row counter / cfg_height width
- PB, 8: bits per channel
- NCH, 1: channels per pixel beat (≥1)
- DEPTH, 16: FIFO entries (power of two, ≥2); AW = $clog2(DEPTH)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cfg_width  in  XB  pixels per line; sampled only in IDLE
- cfg_height  in  YB  lines per frame; sampled only in IDLE
- px_in_data  in  NCH*PB  input beat; channel k in bits [k*PB +: PB]
- px_in_valid  in  1  input beat valid
- px_in_ready  out  1  FIFO can accept a beat
- px_out_data  out  NCH*PB  head-of-FIFO beat
- px_out_valid  out  1  beat valid (ACTIVE state and FIFO not empty)
- px_out_ready  in  1  downstream accepts
- col_count  out  XB  column of the current px_out beat
- row_count  out  YB  row of the current px_out beat
- px_out_sol, px_out_eol, px_out_sof, px_out_eof  out  1 each  position flags
- fifo_level  out  AW+1  current occupancy, 0..DEPTH
- frame_done  out  1  one-cycle pulse after the eof beat is accepted
- cfg_err  out  1  high while IDLE with latched width or height equal to 0
- frame_err  out  1  one-cycle resync pulse (macro only; otherwise tied 0)

## Operation
- Write side: push = px_in_valid & px_in_ready; px_in_ready = (fifo_level != DEPTH). Pushes are independent of FSM state.
- Read side: pop = px_out_valid & px_out_ready.
- FSM IDLE:
  - latch cfg_width/cfg_height every cycle;
  - if both are non-zero, go to ACTIVE next cycle with col = row = 0;
  - otherwise cfg_err = 1 and remain in IDLE;
  - px_out_valid = 0 throughout.
- FSM ACTIVE: on each pop,
  - if col == W-1 (eol): col ← 0;
    - if row == H-1 (eof): row ← 0, frame_done ← 1, go to IDLE;
    - else row ← row+1;
  - else col ← col+1.
- Flags are combinational from the counters: sol = (col==0); eol = (col==W-1); sof = sol & (row==0); eof = eol & (row==H-1).
- W = 1 and/or H = 1 are legal; every beat is then sol & eol, and the single row is both first and last.
- Counters never exceed W-1 / H-1. All compares are on latched values, so cfg changes in ACTIVE have no effect.
- rst: flushes the FIFO and clears pointers.
  - All outputs reset to 0, except px_in_ready = 1.
  - State goes to IDLE.
  - Reset in mid-frame discards any partial frame.

## Timing
- Latency is 1 cycle: a beat pushed at edge t is visible on px_out_data/px_out_valid after edge t, if ACTIVE. There is no same-cycle bypass when the FIFO is empty.
- px_in_ready depends only on registered level. A pop in the same cycle does not raise ready while full; a push is taken the cycle after.
- Simultaneous push and pop: level is unchanged. This is legal at any non-full level, including level 1.
- px_out_data, px_out_valid and the flags stay stable while px_out_valid & ~px_out_ready.
- Between frames the FSM spends exactly 1 IDLE cycle, and px_out_valid is low in that cycle.
- frame_done is asserted during that IDLE cycle.

## Configuration
- PXIN_SOF_RESYNC_EN defined:
  - adds input px_in_sof (1 bit), qualified by px_in_valid and stored with the beat; FIFO width becomes NCH*PB+1;
  - a popped beat carrying sof while ACTIVE and not at (0,0) forces the position of that beat to (0,0), using the current latched config;
  - frame_err pulses for 1 cycle, and counting continues from (0,1) or (1,0);
  - an sof beat at (0,0) is normal.
- Not defined: no px_in_sof port, FIFO width is NCH*PB, frame_err is tied 0.

## Structure
- Package pxin_pkg holds:
  - state enum {IDLE, ACTIVE};
  - default parameter constants;
  - the FIFO-width helper function, which returns NCH*PB (+1 when the macro is defined).
- One sub-module, pxin_fifo:
  - parametrised in width and depth, FWFT;
  - synchronous active-high reset;
  - ports: push/pop, full, level, head data.
- The FSM, counters and flag logic stay in pixel_ingress.

## Test plan
- W=4, H=2, NCH=3, out_ready=1, 8 back-to-back beats:
  - expect positions (0,0)…(3,1) with eol on cols 3;
  - sof only on beat 0, eof only on beat 7;
  - frame_done one cycle after beat 7 is popped, then px_out_valid low for 1 cycle.
- DEPTH=4, out_ready=0, in_valid held for 6 cycles:
  - 4 beats accepted, px_in_ready low from cycle 4, fifo_level=4;
  - release out_ready: data order preserved, no loss or duplicate.
- W=1, H=1: every beat has sol=eol=sof=eof=1, and frame_done follows each pop.
- cfg_width=0 at reset release: cfg_err=1, px_out_valid=0; set width=5 → ACTIVE next cycle, cfg_err=0.
- rst asserted for 1 cycle at position (2,1) with FIFO level 3:
  - level→0, counters→0, state→IDLE;
  - the next frame starts at (0,0).
- With PXIN_SOF_RESYNC_EN, sof on beat 3 of a W=8 frame:
  - beat 3 reports (0,0) with sof=1, frame_err pulses once;
  - beat 4 reports (1,0).

Source files
------------

// File: rtl/pxin_pkg.sv
// Shared types and constants for the pixel ingress block.
// PXIN_SOF_RESYNC_EN widens each FIFO entry by one bit to carry the per-beat sof marker.
package pxin_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } pxin_state_e;

    localparam int XB_DEF    = 10;
    localparam int YB_DEF    = 10;
    localparam int PB_DEF    = 8;
    localparam int NCH_DEF   = 1;
    localparam int DEPTH_DEF = 16;

    function automatic int pxin_fifo_w(input int nch, input int pb);
`ifdef PXIN_SOF_RESYNC_EN
        return nch * pb + 1;
`else
        return nch * pb;
`endif
    endfunction

endpackage

// File: rtl/pxin_fifo.sv
// First-word-fall-through FIFO: the head entry is readable combinationally whenever level != 0.
// Synchronous active-high reset clears pointers and level; storage is left uninitialised.
module pxin_fifo #(
    parameter int  W     = 8,
    parameter int  DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wr_data,
    output logic         full,
    output logic         empty,
    output logic [AW:0]  level,
    output logic [W-1:0] head
);

    localparam logic [AW:0]   FULL_LVL = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   ONE_LVL  = (AW + 1)'(1);
    localparam logic [AW-1:0] ONE_PTR  = AW'(1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          push_ok, pop_ok;

    assign full    = (level_q == FULL_LVL);
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign head    = mem_q[rd_ptr_q];
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + ONE_PTR;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + ONE_PTR;
        end
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + ONE_LVL;
            2'b01:   level_d = level_q - ONE_LVL;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/pixel_ingress.sv
// Pixel stream ingress: FWFT buffering plus per-beat column/row position and line/frame flags.
// Define PXIN_SOF_RESYNC_EN to add px_in_sof and realign the frame position on an unexpected sof.
module pixel_ingress
    import pxin_pkg::*;
#(
    parameter int  XB    = XB_DEF,
    parameter int  YB    = YB_DEF,
    parameter int  PB    = PB_DEF,
    parameter int  NCH   = NCH_DEF,
    parameter int  DEPTH = DEPTH_DEF,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XB-1:0]     cfg_width,
    input  logic [YB-1:0]     cfg_height,
    input  logic [NCH*PB-1:0] px_in_data,
    input  logic              px_in_valid,
`ifdef PXIN_SOF_RESYNC_EN
    input  logic              px_in_sof,
`endif
    output logic              px_in_ready,
    output logic [NCH*PB-1:0] px_out_data,
    output logic              px_out_valid,
    input  logic              px_out_ready,
    output logic [XB-1:0]     col_count,
    output logic [YB-1:0]     row_count,
    output logic              px_out_sol,
    output logic              px_out_eol,
    output logic              px_out_sof,
    output logic              px_out_eof,
    output logic [AW:0]       fifo_level,
    output logic              frame_done,
    output logic              cfg_err,
    output logic              frame_err
);

    localparam int            DW    = NCH * PB;
    localparam int            FW    = pxin_fifo_w(NCH, PB);
    localparam logic [XB-1:0] ONE_X = XB'(1);
    localparam logic [YB-1:0] ONE_Y = YB'(1);

    pxin_state_e   state_q, state_d;
    logic [XB-1:0] width_q, width_d;
    logic [YB-1:0] height_q, height_d;
    logic [XB-1:0] col_q, col_d, pos_col;
    logic [YB-1:0] row_q, row_d, pos_row;
    logic          frame_done_q, frame_done_d;
    logic          frame_err_q, frame_err_d;
    logic          cfg_err_q, cfg_err_d;

    logic          fifo_full, fifo_empty;
    logic          push, pop, active, head_sof, resync, at_eol, at_eof;
    logic [FW-1:0] fifo_wdata, fifo_head;

`ifdef PXIN_SOF_RESYNC_EN
    assign fifo_wdata = {px_in_sof, px_in_data};
    assign head_sof   = fifo_head[FW-1];
`else
    assign fifo_wdata = px_in_data;
    assign head_sof   = 1'b0;
`endif

    pxin_fifo #(
        .W     (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .wr_data (fifo_wdata),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level),
        .head    (fifo_head)
    );

    assign active       = (state_q == ACTIVE);
    assign px_in_ready  = ~fifo_full;
    assign push         = px_in_valid & px_in_ready;
    assign px_out_valid = active & ~fifo_empty;
    assign pop          = px_out_valid & px_out_ready;
    assign px_out_data  = fifo_empty ? '0 : fifo_head[DW-1:0];

    // An sof beat arriving away from (0,0) is reported at (0,0) while it sits at the head.
    assign resync  = px_out_valid & head_sof & ((col_q != '0) | (row_q != '0));
    assign pos_col = resync ? '0 : col_q;
    assign pos_row = resync ? '0 : row_q;
    assign at_eol  = (pos_col == width_q - ONE_X);
    assign at_eof  = at_eol & (pos_row == height_q - ONE_Y);

    assign col_count  = pos_col;
    assign row_count  = pos_row;
    assign px_out_sol = active & (pos_col == '0);
    assign px_out_eol = active & at_eol;
    assign px_out_sof = px_out_sol & (pos_row == '0);
    assign px_out_eof = active & at_eof;

    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;
    assign cfg_err    = cfg_err_q;

    always_comb begin
        state_d      = state_q;
        width_d      = width_q;
        height_d     = height_q;
        col_d        = col_q;
        row_d        = row_q;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;
        cfg_err_d    = cfg_err_q;
        case (state_q)
            IDLE: begin
                width_d  = cfg_width;
                height_d = cfg_height;
                col_d    = '0;
                row_d    = '0;
                if ((cfg_width != '0) && (cfg_height != '0)) begin
                    state_d   = ACTIVE;
                    cfg_err_d = 1'b0;
                end else begin
                    cfg_err_d = 1'b1;
                end
            end
            ACTIVE: begin
                cfg_err_d = 1'b0;
                if (pop) begin
                    frame_err_d = resync;
                    if (at_eol) begin
                        col_d = '0;
                        if (at_eof) begin
                            row_d        = '0;
                            frame_done_d = 1'b1;
                            state_d      = IDLE;
                        end else begin
                            row_d = pos_row + ONE_Y;
                        end
                    end else begin
                        col_d = pos_col + ONE_X;
                        row_d = pos_row;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            width_q      <= '0;
            height_q     <= '0;
            col_q        <= '0;
            row_q        <= '0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            width_q      <= width_d;
            height_q     <= height_d;
            col_q        <= col_d;
            row_q        <= row_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

endmodule

// File: tb/tb_pixel_ingress.sv
// Directed bench for pixel_ingress (NCH=3, DEPTH=4); the sof resync steps run when PXIN_SOF_RESYNC_EN is defined.
module tb_pixel_ingress;

    localparam int XB    = 10;
    localparam int YB    = 10;
    localparam int PB    = 8;
    localparam int NCH   = 3;
    localparam int DEPTH = 4;
    localparam int AW    = $clog2(DEPTH);

    logic              clk = 1'b0;
    logic              rst;
    logic [XB-1:0]     cfg_width;
    logic [YB-1:0]     cfg_height;
    logic [NCH*PB-1:0] px_in_data;
    logic              px_in_valid;
    logic              px_in_sof;
    logic              px_in_ready;
    logic [NCH*PB-1:0] px_out_data;
    logic              px_out_valid;
    logic              px_out_ready;
    logic [XB-1:0]     col_count;
    logic [YB-1:0]     row_count;
    logic              px_out_sol, px_out_eol, px_out_sof, px_out_eof;
    logic [AW:0]       fifo_level;
    logic              frame_done, cfg_err, frame_err;

    int checks   = 0;
    int failures = 0;

    pixel_ingress #(
        .XB(XB), .YB(YB), .PB(PB), .NCH(NCH), .DEPTH(DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_width    (cfg_width),
        .cfg_height   (cfg_height),
        .px_in_data   (px_in_data),
        .px_in_valid  (px_in_valid),
`ifdef PXIN_SOF_RESYNC_EN
        .px_in_sof    (px_in_sof),
`endif
        .px_in_ready  (px_in_ready),
        .px_out_data  (px_out_data),
        .px_out_valid (px_out_valid),
        .px_out_ready (px_out_ready),
        .col_count    (col_count),
        .row_count    (row_count),
        .px_out_sol   (px_out_sol),
        .px_out_eol   (px_out_eol),
        .px_out_sof   (px_out_sof),
        .px_out_eof   (px_out_eof),
        .fifo_level   (fifo_level),
        .frame_done   (frame_done),
        .cfg_err      (cfg_err),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] beat(input int k);
        beat = {8'(8'hA0 + k), 8'(8'h50 + k), 8'(8'h10 + k)};
    endfunction

    initial begin
        rst = 1'b1; cfg_width = 10'd4; cfg_height = 10'd2;
        px_in_data = '0; px_in_valid = 1'b0; px_in_sof = 1'b0; px_out_ready = 1'b0;
        step(); step();

        // reset state
        chk("rst_ready", px_in_ready, 1);
        chk("rst_valid", px_out_valid, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_col", col_count, 0);
        chk("rst_row", row_count, 0);
        chk("rst_flags", {px_out_sol, px_out_eol, px_out_sof, px_out_eof}, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_cfgerr", cfg_err, 0);
        chk("rst_frerr", frame_err, 0);
        chk("rst_data", px_out_data, 0);

        // W=4 H=2 back-to-back frame of 8 beats
        rst = 1'b0; px_out_ready = 1'b1; px_in_valid = 1'b1; px_in_data = beat(0);
        for (int k = 0; k < 8; k++) begin
            step();
            chk("f1_valid", px_out_valid, 1);
            chk("f1_data", px_out_data, beat(k));
            chk("f1_col", col_count, k % 4);
            chk("f1_row", row_count, k / 4);
            chk("f1_sol", px_out_sol, (k % 4) == 0);
            chk("f1_eol", px_out_eol, (k % 4) == 3);
            chk("f1_sof", px_out_sof, k == 0);
            chk("f1_eof", px_out_eof, k == 7);
            chk("f1_done", frame_done, 0);
            if (k == 7) px_in_valid = 1'b0;
            else        px_in_data = beat(k + 1);
        end
        step();
        chk("f1_done_pulse", frame_done, 1);
        chk("f1_idle_valid", px_out_valid, 0);
        chk("f1_idle_level", fifo_level, 0);
        step();
        chk("f1_done_clear", frame_done, 0);
        chk("f1_post_valid", px_out_valid, 0);

        // fill DEPTH=4 FIFO with downstream stalled
        px_out_ready = 1'b0; px_in_valid = 1'b1; px_in_data = beat(16);
        for (int c = 0; c < 6; c++) begin
            step();
            chk("fill_level", fifo_level, (c + 1 < 4) ? c + 1 : 4);
            chk("fill_ready", px_in_ready, (c + 1) < 4);
            if (c < 3) px_in_data = beat(17 + c);
        end
        chk("fill_valid", px_out_valid, 1);
        chk("fill_data_stable", px_out_data, beat(16));
        px_in_valid = 1'b0; px_out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("drain_data", px_out_data, beat(16 + k));
            chk("drain_col", col_count, k);
            chk("drain_row", row_count, 0);
            chk("drain_eol", px_out_eol, k == 3);
            step();
        end
        chk("drain_level", fifo_level, 0);
        chk("drain_valid", px_out_valid, 0);
        chk("drain_next_row", row_count, 1);
        chk("drain_next_col", col_count, 0);

        // reach (2,1) with level 3, then reset mid-frame
        px_out_ready = 1'b0; px_in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            px_in_data = beat(32 + k);
            step();
        end
        chk("mid_level3", fifo_level, 3);
        px_out_ready = 1'b1;
        for (int k = 3; k < 5; k++) begin
            px_in_data = beat(32 + k);
            step();
            chk("mid_pushpop_level", fifo_level, 3);
        end
        chk("mid_col", col_count, 2);
        chk("mid_row", row_count, 1);
        chk("mid_data", px_out_data, beat(34));
        rst = 1'b1; px_in_valid = 1'b0; px_out_ready = 1'b0;
        cfg_width = 10'd1; cfg_height = 10'd1;
        step();
        chk("mrst_level", fifo_level, 0);
        chk("mrst_col", col_count, 0);
        chk("mrst_row", row_count, 0);
        chk("mrst_valid", px_out_valid, 0);
        chk("mrst_ready", px_in_ready, 1);

        // W=1 H=1 frames after reset
        rst = 1'b0; px_in_valid = 1'b1; px_in_data = beat(48); px_out_ready = 1'b1;
        step();
        chk("w1_valid0", px_out_valid, 1);
        chk("w1_data0", px_out_data, beat(48));
        chk("w1_pos0", {col_count, row_count}, 0);
        chk("w1_flags0", {px_out_sol, px_out_eol, px_out_sof, px_out_eof}, 4'hF);
        px_in_data = beat(49);
        step();
        chk("w1_done0", frame_done, 1);
        chk("w1_idle_valid", px_out_valid, 0);
        chk("w1_idle_level", fifo_level, 1);
        px_in_valid = 1'b0;
        step();
        chk("w1_done_clr", frame_done, 0);
        chk("w1_data1", px_out_data, beat(49));
        chk("w1_flags1", {px_out_sol, px_out_eol, px_out_sof, px_out_eof}, 4'hF);
        cfg_width = 10'd0;
        #1;
        chk("w1_cfg_active_ignored", px_out_eol, 1);

        // zero width in IDLE holds off ACTIVE
        px_in_valid = 1'b1; px_in_data = beat(50);
        step();
        chk("w1_done1", frame_done, 1);
        chk("w1_cfgerr_low", cfg_err, 0);
        px_in_valid = 1'b0;
        step();
        chk("cfg0_err", cfg_err, 1);
        chk("cfg0_valid", px_out_valid, 0);
        chk("cfg0_level", fifo_level, 1);
        cfg_width = 10'd5;
        step();
        chk("cfg5_err", cfg_err, 0);
        chk("cfg5_valid", px_out_valid, 1);
        chk("cfg5_data", px_out_data, beat(50));
        chk("cfg5_sof", px_out_sof, 1);
        chk("cfg5_eol", px_out_eol, 0);

`ifdef PXIN_SOF_RESYNC_EN
        // sof on beat 3 of a W=8 frame
        rst = 1'b1; px_in_valid = 1'b0; cfg_width = 10'd8; cfg_height = 10'd2;
        step();
        rst = 1'b0; px_in_valid = 1'b1; px_in_data = beat(64); px_in_sof = 1'b1; px_out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("rs_data", px_out_data, beat(64 + k));
            chk("rs_col", col_count, (k < 3) ? k : k - 3);
            chk("rs_row", row_count, 0);
            chk("rs_sof", px_out_sof, (k == 0) || (k == 3));
            chk("rs_frerr", frame_err, k == 4);
            if (k == 5) px_in_valid = 1'b0;
            px_in_data = beat(65 + k);
            px_in_sof  = ((k + 1) == 3);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
